hazard_unit_p: RTL

HAZARD_UNIT_P -- requirements
Module: hazard_unit_p

---
 rtl/hazard_unit_p.sv | 113 +++++++++++
 1 files changed

// File: rtl/hazard_unit_p.sv
// Decode-stage hazard unit: tracks in-flight writers per pipeline stage, selects the
// nearest forwarding source for rs/rt and raises a load-use stall when needed.
module hazard_unit_p #(
   parameter int REG_AW      = 4,
   parameter int NSTAGE      = 3,
   parameter int LOAD_LAT    = 1,
   parameter int LW_OP       = 6,
   parameter int ZERO_REG_EN = 1,
   localparam int FW_W       = $clog2(NSTAGE + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic [REG_AW-1:0] rd,
   input  logic              rw,
   input  logic [5:0]        op_code,
   input  logic              id_valid,
   input  logic              flush,
   output logic [FW_W-1:0]   fwa,
   output logic [FW_W-1:0]   fwb,
   output logic              stall,
   output logic [15:0]       stall_cnt
);

   // Entry k describes the instruction currently sitting in producer stage k.
   logic [REG_AW-1:0] trk_rd [1:NSTAGE];
   logic [NSTAGE:1]   trk_rw;
   logic [NSTAGE:1]   trk_ld;

   logic [NSTAGE:1]   match_a;
   logic [NSTAGE:1]   match_b;
   logic              load_hit_a;
   logic              load_hit_b;
   logic              issue;

   logic              rs_is_zero;
   logic              rt_is_zero;

   assign rs_is_zero = (ZERO_REG_EN != 0) && (rs == '0);
   assign rt_is_zero = (ZERO_REG_EN != 0) && (rt == '0);

   // NOTE: every always_comb output gets a default before any conditional write,
   // otherwise synthesis infers a latch to hold the value on untaken paths.
   always_comb begin
      match_a = '0;
      match_b = '0;
      for (int k = 1; k <= NSTAGE; k++) begin
         match_a[k] = trk_rw[k] && (trk_rd[k] == rs) && !rs_is_zero;
         match_b[k] = trk_rw[k] && (trk_rd[k] == rt) && !rt_is_zero;
      end
   end

   // Scanning from the oldest stage towards stage 1 lets the nearest match win.
   always_comb begin
      fwa        = '0;
      fwb        = '0;
      load_hit_a = 1'b0;
      load_hit_b = 1'b0;
      for (int k = NSTAGE; k >= 1; k--) begin
         if (match_a[k]) begin
            fwa        = FW_W'(k);
            load_hit_a = trk_ld[k] && (k <= LOAD_LAT);
         end
         if (match_b[k]) begin
            fwb        = FW_W'(k);
            load_hit_b = trk_ld[k] && (k <= LOAD_LAT);
         end
      end
   end

   // Flush squashes the decode instruction, so it can never be the one stalled.
   assign stall = id_valid && !flush && (load_hit_a || load_hit_b);
   assign issue = id_valid && !flush && !stall;

   // NOTE: the tracker is a handful of flops rather than a RAM, so it is cleared by
   // the async reset like any other register; the pipeline must restart empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 1; k <= NSTAGE; k++) begin
            trk_rd[k] <= '0;
         end
         trk_rw <= '0;
         trk_ld <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage read its neighbour's old
         // value, so the shift order inside the loop does not matter.
         for (int k = NSTAGE; k >= 2; k--) begin
            trk_rd[k] <= trk_rd[k-1];
            trk_rw[k] <= trk_rw[k-1];
            trk_ld[k] <= trk_ld[k-1];
         end
         if (issue) begin
            trk_rd[1] <= rd;
            trk_rw[1] <= rw;
            trk_ld[1] <= (op_code == 6'(LW_OP));
         end else begin
            trk_rd[1] <= '0;
            trk_rw[1] <= 1'b0;
            trk_ld[1] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule
